counter_sched: RTL

//  Time-shares one interval counter (flex-counter semantics: counts 1..rollover_val)

---
 rtl/counter_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/counter_sched.sv
// counter_sched
//   Shares one interval counter among NUM_REQ requesters. A round-robin
//   arbiter picks a requester. The chosen requester's rollover value is
//   latched, and the counter then counts 1..rv on tick strobes. When the
//   interval completes, a one-cycle done pulse goes back to that requester.
//
// Ports
//   clk        in   1                 system clock, rising edge
//   rst        in   1                 synchronous active-high reset
//   req        in   NUM_REQ           level request per requester
//   req_val    in   NUM_REQ*CNT_BITS  packed rollover values, requester i at [i*CNT_BITS +: CNT_BITS]
//   tick       in   1                 count-enable strobe, used only while counting
//   abort      in   1                 cancel the active interval
//   grant      out  NUM_REQ           one-hot grant, high in LOAD and COUNT
//   done       out  NUM_REQ           one-cycle completion pulse to the grantee
//   busy       out  1                 high in LOAD, COUNT and DONE
//   cur_id     out  $clog2(NUM_REQ)   index of the last or current grantee
//   count_out  out  CNT_BITS          current count

module counter_sched #(
  parameter int NUM_REQ  = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_BITS-1:0]  req_val,
  input  logic                         tick,
  input  logic                         abort,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   cur_id,
  output logic [CNT_BITS-1:0]          count_out
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_DONE
  } state_t;

  state_t              state, nxt_state;
  logic [CNT_BITS-1:0] rv, nxt_rv;
  logic [ID_W-1:0]     last_winner, nxt_last_winner;
  logic [NUM_REQ-1:0]  nxt_grant, nxt_done;
  logic                nxt_busy;
  logic [ID_W-1:0]     nxt_cur_id;
  logic [CNT_BITS-1:0] nxt_count;

  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     cand;
  logic [CNT_BITS-1:0] cnt_inc;
  logic                abort_now;

  assign cnt_inc   = count_out + CNT_BITS'(1);
  // Dropping the grantee's request cancels the interval in the same way as abort.
  assign abort_now = abort | ~req[cur_id];

  // The round-robin search starts just above the last winner and wraps.
  // The most recent winner is therefore examined last.
  always_comb begin : rr_search
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_winner) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // State and output registers. Every output comes straight from a flop.
  // Reset places the pointer on the top requester, which makes requester 0 the first winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rv          <= '0;
      last_winner <= ID_W'(NUM_REQ - 1);
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      cur_id      <= '0;
      count_out   <= '0;
    end else begin
      state       <= nxt_state;
      rv          <= nxt_rv;
      last_winner <= nxt_last_winner;
      grant       <= nxt_grant;
      done        <= nxt_done;
      busy        <= nxt_busy;
      cur_id      <= nxt_cur_id;
      count_out   <= nxt_count;
    end
  end

  // Next-state and next-output logic. The done default of zero keeps it to a single-cycle pulse.
  always_comb begin : fsm_next
    nxt_state       = state;
    nxt_rv          = rv;
    nxt_last_winner = last_winner;
    nxt_grant       = grant;
    nxt_done        = '0;
    nxt_busy        = busy;
    nxt_cur_id      = cur_id;
    nxt_count       = count_out;

    case (state)
      S_IDLE: begin
        if (found) begin
          nxt_state          = S_LOAD;
          nxt_rv             = req_val[int'(winner)*CNT_BITS +: CNT_BITS];
          nxt_last_winner    = winner;
          nxt_cur_id         = winner;
          nxt_grant          = '0;
          nxt_grant[winner]  = 1'b1;
          nxt_busy           = 1'b1;
          nxt_count          = '0;
        end
      end

      S_LOAD: begin
        if (abort_now) begin
          nxt_state = S_IDLE;
          nxt_grant = '0;
          nxt_busy  = 1'b0;
          nxt_count = '0;
        end else if (rv == '0) begin
          nxt_state        = S_DONE;
          nxt_grant        = '0;
          nxt_done[cur_id] = 1'b1;
        end else begin
          nxt_state = S_COUNT;
        end
      end

      S_COUNT: begin
        // Abort is checked first, so it wins over a tick that would complete the interval.
        if (abort_now) begin
          nxt_state = S_IDLE;
          nxt_grant = '0;
          nxt_busy  = 1'b0;
          nxt_count = '0;
        end else if (tick) begin
          nxt_count = cnt_inc;
          if (cnt_inc == rv) begin
            nxt_state        = S_DONE;
            nxt_grant        = '0;
            nxt_done[cur_id] = 1'b1;
          end
        end
      end

      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_busy  = 1'b0;
      end

      default: begin
        nxt_state = S_IDLE;
        nxt_grant = '0;
        nxt_busy  = 1'b0;
      end
    endcase
  end

endmodule
